// File: rtl/ones_frame_accumulator.sv
// ones_frame_accumulator
//   Sums the per-byte ones counts produced by the upstream 8-bit popcount over
//   a frame of bytes. A frame closes on in_last or on the MAX_WORDS-th accepted
//   byte, whichever comes first. The frame total, byte count, overflow flag and
//   error flag are then presented on a valid/ready output.
//
//   Optional feature, macro ONES_ACC_SAT_EN:
//     defined   - the accumulator saturates at 2^TOTAL_W-1 for the rest of the frame
//     undefined - the accumulator wraps modulo 2^TOTAL_W
//   In both builds out_ovf is sticky for the frame.
//
//   Constraints: TOTAL_W >= 4 and CNT_W wide enough to hold MAX_WORDS.

module ones_frame_accumulator #(
   parameter int MAX_WORDS = 16,
   parameter int TOTAL_W   = 8,
   parameter int CNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_count,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [TOTAL_W-1:0] out_total,
   output logic [CNT_W-1:0]   out_words,
   output logic               out_ovf,
   output logic               out_err
);

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [TOTAL_W-1:0] acc, acc_nxt;
   logic [TOTAL_W:0]   sum;
   logic [CNT_W-1:0]   cnt, cnt_inc;
   logic               ovf, ovf_nxt;
   logic               err, err_nxt;
   logic               accept;
   logic               close;
   logic               handshake;

   assign accept    = in_valid & in_ready;
   assign handshake = out_valid & out_ready;

   // Next values of the running accumulator, counter and sticky flags for an accepted byte.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
      sum     = {1'b0, acc} + {{(TOTAL_W-3){1'b0}}, in_count};
      cnt_inc = cnt + CNT_W'(1);
      ovf_nxt = ovf | sum[TOTAL_W];
      err_nxt = err | (in_count > 4'd8);
`ifdef ONES_ACC_SAT_EN
      // Once the carry fires the value is pinned at all-ones; further adds carry again or add zero.
      acc_nxt = sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
`else
      acc_nxt = sum[TOTAL_W-1:0];
`endif
      close   = accept & (in_last | (cnt_inc == CNT_W'(MAX_WORDS)));
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   // Next-state logic: close a frame on last/max, release it on the output handshake.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ACCUM: if (close)     state_nxt = DONE;
         DONE:  if (handshake) state_nxt = ACCUM;
         default:              state_nxt = ACCUM;
      endcase
   end

   // Output decode: input side open while accumulating, result valid while done.
   always_comb begin
      in_ready  = (state == ACCUM);
      out_valid = (state == DONE);
   end

   // Accumulator, counter, sticky flags and the held frame result.
   always_ff @(posedge clk) begin
      // NOTE: the result registers are reset too, so the output fields read zero straight after reset.
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         err       <= 1'b0;
         out_total <= '0;
         out_words <= '0;
         out_ovf   <= 1'b0;
         out_err   <= 1'b0;
      end else if (handshake) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
         err <= 1'b0;
      end else if (accept) begin
         acc <= acc_nxt;
         cnt <= cnt_inc;
         ovf <= ovf_nxt;
         err <= err_nxt;
         if (close) begin
            out_total <= acc_nxt;
            out_words <= cnt_inc;
            out_ovf   <= ovf_nxt;
            out_err   <= err_nxt;
         end
      end
   end

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// tb_ones_frame_accumulator
//   Directed bench for ones_frame_accumulator. A default instance (TOTAL_W=8,
//   MAX_WORDS=16) covers framing, backpressure, reset and error flagging; a
//   TOTAL_W=4 instance covers wrap/saturation (ONES_ACC_SAT_EN selects which).
//   Inputs are driven 1 ns after the rising edge; outputs are sampled on the
//   falling edge.

module tb_ones_frame_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_last, out_ready;
   logic [3:0] in_count;
   logic       in_ready, out_valid, out_ovf, out_err;
   logic [7:0] out_total, out_words;

   logic       w_valid, w_last;
   logic [3:0] w_count;
   logic       w_in_ready, w_out_valid, w_ovf, w_err;
   logic [3:0] w_total;
   logic [7:0] w_words;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int total;
      int words;
      int ovf;
      int err;
   } frame_t;

   frame_t res_q[$];

   always #5 clk = ~clk;

   ones_frame_accumulator #(.MAX_WORDS(16), .TOTAL_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_total(out_total), .out_words(out_words), .out_ovf(out_ovf), .out_err(out_err)
   );

   ones_frame_accumulator #(.MAX_WORDS(16), .TOTAL_W(4), .CNT_W(8)) dut_w4 (
      .clk(clk), .rst(rst),
      .in_valid(w_valid), .in_ready(w_in_ready), .in_count(w_count), .in_last(w_last),
      .out_valid(w_out_valid), .out_ready(1'b1),
      .out_total(w_total), .out_words(w_words), .out_ovf(w_ovf), .out_err(w_err)
   );

   // Record every completed output handshake of the default instance.
   always @(negedge clk) begin
      if (out_valid && out_ready)
         res_q.push_back('{int'(out_total), int'(out_words), int'(out_ovf), int'(out_err)});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one byte count and hold it until accepted; called 1 ns after a rising edge.
   task automatic send(input logic [3:0] c, input logic l);
      bit got = 1'b0;
      in_valid = 1'b1;
      in_count = c;
      in_last  = l;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!got) check("send_timeout", 32'd0, 32'd1);
   endtask

   // Check the result cycle right after the closing byte, then let the handshake edge pass.
   task automatic check_frame(input string tag, input int total, input int words,
                              input int ovf, input int err);
      @(negedge clk);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_total"}, out_total, total);
      check({tag, "_words"}, out_words, words);
      check({tag, "_ovf"}, out_ovf, ovf);
      check({tag, "_err"}, out_err, err);
      @(posedge clk);
      #1;
   endtask

   task automatic check_q(input string tag, input int idx, input int total, input int words);
      if (idx < res_q.size()) begin
         check({tag, "_total"}, res_q[idx].total, total);
         check({tag, "_words"}, res_q[idx].words, words);
         check({tag, "_ovf"}, res_q[idx].ovf, 0);
      end else begin
         check({tag, "_missing"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_last = 1'b0; in_count = 4'd0; out_ready = 1'b1;
      w_valid = 1'b0; w_last = 1'b0; w_count = 4'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_total", out_total, 0);
      check("rst_words", out_words, 0);
      check("rst_ovf", out_ovf, 0);
      check("rst_err", out_err, 0);
      @(posedge clk);
      #1;

      // Bytes 0x57,0xCC,0x33,0xFF,0x00 -> counts 5,4,4,8,0.
      send(4'd5, 1'b0);
      send(4'd4, 1'b0);
      send(4'd4, 1'b0);
      send(4'd8, 1'b0);
      send(4'd0, 1'b1);
      check_frame("f5", 21, 5, 0, 0);
      @(negedge clk);
      check("f5_after_valid", out_valid, 0);
      check("f5_after_in_ready", in_ready, 1);
      check("f5_one_done_cycle", res_q.size(), 1);
      @(posedge clk);
      #1;

      // 20 bytes of 0xFF: force-close at 16, then a 4-byte frame.
      res_q.delete();
      for (int i = 1; i <= 20; i++) send(4'd8, (i == 20));
      repeat (2) @(posedge clk);
      #1;
      check("max_frames", res_q.size(), 2);
      check_q("max_f0", 0, 128, 16);
      check_q("max_f1", 1, 32, 4);

      // in_last on the 16th byte closes exactly one frame.
      res_q.delete();
      for (int i = 1; i <= 16; i++) send(4'd1, (i == 16));
      send(4'd2, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("lastmax_frames", res_q.size(), 2);
      check_q("lastmax_f0", 0, 16, 16);
      check_q("lastmax_f1", 1, 2, 1);

      // Backpressure: hold the result 5 cycles with a competing input offered.
      res_q.delete();
      out_ready = 1'b0;
      send(4'd3, 1'b0);
      send(4'd2, 1'b1);
      in_valid = 1'b1; in_count = 4'd7; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_total", out_total, 5);
         check("bp_words", out_words, 2);
         check("bp_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      check("bp_hs_valid", out_valid, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_released", out_valid, 0);
      check("bp_one_frame", res_q.size(), 1);
      @(posedge clk);
      #1;
      send(4'd1, 1'b1);
      check_frame("bp_next", 1, 1, 0, 0);

      // Narrow accumulator: 8+8 overflows a 4-bit total.
      w_valid = 1'b1; w_count = 4'd8; w_last = 1'b0;
      @(posedge clk);
      #1 w_last = 1'b1;
      @(posedge clk);
      #1 w_valid = 1'b0; w_last = 1'b0;
      @(negedge clk);
      check("w4_valid", w_out_valid, 1);
`ifdef ONES_ACC_SAT_EN
      check("w4_total", w_total, 15);
`else
      check("w4_total", w_total, 0);
`endif
      check("w4_ovf", w_ovf, 1);
      check("w4_words", w_words, 2);
      @(posedge clk);
      #1 w_valid = 1'b1; w_count = 4'd3; w_last = 1'b1;
      @(negedge clk);
      check("w4_ready_again", w_in_ready, 1);
      @(posedge clk);
      #1 w_valid = 1'b0; w_last = 1'b0;
      @(negedge clk);
      check("w4_next_valid", w_out_valid, 1);
      check("w4_next_total", w_total, 3);
      check("w4_next_ovf", w_ovf, 0);
      @(posedge clk);
      #1;

      // Reset mid-frame discards the partial sum.
      send(4'd7, 1'b0);
      send(4'd7, 1'b0);
      send(4'd7, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_valid", out_valid, 0);
      check("midrst_total", out_total, 0);
      check("midrst_words", out_words, 0);
      @(posedge clk);
      #1;
      send(4'd2, 1'b1);
      check_frame("midrst_next", 2, 1, 0, 0);

      // Illegal count 9 is summed and flagged; the next clean frame clears the flag.
      send(4'd1, 1'b0);
      send(4'd9, 1'b1);
      check_frame("err", 10, 2, 0, 1);
      send(4'd4, 1'b1);
      check_frame("err_clean", 4, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
